// File: rtl/bus_mem_slave.sv
// Single-master bus slave: request/grant handshake, optional wait states, word memory with read/write/atomic increment.
// Define BUS_MEM_SLAVE_PARITY_EN to build one even-parity bit per word and report parity errors on err.
module bus_mem_slave #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 8,
   parameter int DEPTH    = 256,
   parameter int WAIT_CYC = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   output logic              gnt,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              rdy,
   output logic              err
);

   localparam int         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] WAIT_LD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_GRANT  = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_ACCESS = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   localparam logic [1:0] M_NOP  = 2'b00;
   localparam logic [1:0] M_RD   = 2'b01;
   localparam logic [1:0] M_WR   = 2'b10;
   localparam logic [1:0] M_INC  = 2'b11;

   logic [2:0]        state_q, state_d;
   logic              gnt_q, gnt_d;
   logic              rdy_q, rdy_d;
   logic              err_q, err_d;
   logic              err_pend_q, err_pend_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [3:0]        wcnt_q, wcnt_d;
   logic [1:0]        mode_q, mode_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] mem_rd_q;
   logic [IDX_W-1:0]  rd_idx;
   logic [IDX_W-1:0]  wr_idx;
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              in_range;
   logic              perr;

   // The read port follows the live address in GRANT so the word is ready when ACCESS follows start directly.
   assign rd_idx   = (state_q == S_GRANT) ? addr[IDX_W-1:0] : addr_q[IDX_W-1:0];
   assign wr_idx   = addr_q[IDX_W-1:0];
   assign in_range = (32'(addr_q) < DEPTH);

`ifdef BUS_MEM_SLAVE_PARITY_EN
   logic par_mem [DEPTH];
   logic par_rd_q;

   always_ff @(posedge clk) begin
      par_rd_q <= par_mem[rd_idx];
      if (wr_en) begin
         par_mem[wr_idx] <= ^wr_data;
      end
   end

   assign perr = par_rd_q ^ (^mem_rd_q);
`else
   assign perr = 1'b0;
`endif

   always_ff @(posedge clk) begin
      mem_rd_q <= mem[rd_idx];
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   always_comb begin
      state_d    = state_q;
      wcnt_d     = wcnt_q;
      mode_d     = mode_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      err_pend_d = err_pend_q;
      wr_en      = 1'b0;
      wr_data    = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (req) state_d = S_GRANT;
         end
         S_GRANT: begin
            if (start) begin
               mode_d     = mode;
               addr_d     = addr;
               wdata_d    = wdata;
               err_pend_d = 1'b0;
               wcnt_d     = WAIT_LD;
               if (mode == M_NOP)      state_d = S_DONE;
               else if (WAIT_CYC > 0)  state_d = S_WAIT;
               else                    state_d = S_ACCESS;
            end else if (!req) begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            if (wcnt_q == 4'd0) state_d = S_ACCESS;
            else                wcnt_d  = wcnt_q - 4'd1;
         end
         S_ACCESS: begin
            state_d = S_DONE;
            if (!in_range) begin
               rdata_d    = '0;
               err_pend_d = 1'b1;
            end else begin
               case (mode_q)
                  M_RD: begin
                     rdata_d    = mem_rd_q;
                     err_pend_d = perr;
                  end
                  M_WR: begin
                     wr_en      = 1'b1;
                     err_pend_d = 1'b0;
                  end
                  M_INC: begin
                     // A corrupted word is still returned but never written back incremented.
                     rdata_d    = mem_rd_q;
                     wr_data    = mem_rd_q + 1'b1;
                     wr_en      = !perr;
                     err_pend_d = perr;
                  end
                  default: err_pend_d = 1'b0;
               endcase
            end
         end
         S_DONE: begin
            state_d = req ? S_GRANT : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (rst) wr_en = 1'b0;
   end

   assign gnt_d = (state_d != S_IDLE);
   assign rdy_d = (state_q == S_DONE);
   assign err_d = (state_q == S_DONE) && err_pend_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         gnt_q      <= 1'b0;
         rdy_q      <= 1'b0;
         err_q      <= 1'b0;
         err_pend_q <= 1'b0;
         rdata_q    <= '0;
         wcnt_q     <= 4'd0;
         mode_q     <= M_NOP;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         rdy_q      <= rdy_d;
         err_q      <= err_d;
         err_pend_q <= err_pend_d;
         rdata_q    <= rdata_d;
         wcnt_q     <= wcnt_d;
         mode_q     <= mode_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
      end
   end

   assign gnt   = gnt_q;
   assign rdy   = rdy_q;
   assign err   = err_q;
   assign rdata = rdata_q;

endmodule
